// File: rtl/instr_fetch_if.sv
// Instruction-memory read port, decode handshake and redirect/fault signals of instr_fetch.
// master = fetch sequencer side, slave = memory/decode/branch side.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            mem_dout;
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect_en;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  fetch_fault;

    modport master (
        output rd_en, rd_addr, instr, instr_addr, instr_valid, fetch_fault,
        input  mem_dout, instr_ready, redirect_en, redirect_addr
    );

    modport slave (
        input  rd_en, rd_addr, instr, instr_addr, instr_valid, fetch_fault,
        output mem_dout, instr_ready, redirect_en, redirect_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// Byte-serial fetch: four 1-byte reads from a sync-read memory assembled into a little-endian word.
// Optional macro INSTR_FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a sticky fault.
module instr_fetch #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic           PC,
    input logic           rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_t;

    function automatic logic [ADDR_WIDTH-1:0] align4(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = align4(RESET_VECTOR);

    state_t                state;
    logic [2:0]            k;
    logic [2:0]            k_inc;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [31:0]           instr_q;
    logic [ADDR_WIDTH-1:0] instr_addr_q;
    logic                  valid_q;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    logic                  fault_q;
`endif

    assign k_inc           = k + 3'd1;
    assign redirect_target = align4(bus.redirect_addr);

    always_ff @(posedge PC or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            fetch_pc     <= PC_INIT;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= PC_INIT;
            instr_q      <= '0;
            instr_addr_q <= PC_INIT;
            valid_q      <= 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else if (bus.redirect_en && state != FAULT) begin
            // Redirect beats the handshake: the presented word counts as consumed.
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_addr[1:0] != 2'b00) begin
                state   <= FAULT;
                k       <= '0;
                rd_en_q <= 1'b0;
                valid_q <= 1'b0;
                fault_q <= 1'b1;
            end else
`endif
            begin
                state     <= FETCH;
                k         <= '0;
                fetch_pc  <= redirect_target;
                rd_en_q   <= 1'b1;
                rd_addr_q <= redirect_target;
                valid_q   <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    k         <= '0;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= fetch_pc;
                end
                FETCH: begin
                    // Data for the read issued in cycle k-1 arrives during cycle k.
                    case (k)
                        3'd1:    instr_q[7:0]   <= bus.mem_dout;
                        3'd2:    instr_q[15:8]  <= bus.mem_dout;
                        3'd3:    instr_q[23:16] <= bus.mem_dout;
                        3'd4:    instr_q[31:24] <= bus.mem_dout;
                        default: ;
                    endcase
                    if (k == 3'd4) begin
                        state        <= VALID;
                        k            <= '0;
                        valid_q      <= 1'b1;
                        instr_addr_q <= fetch_pc;
                    end else begin
                        k <= k_inc;
                    end
                    if (k < 3'd3) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= fetch_pc + ADDR_WIDTH'(k_inc);
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                end
                VALID: begin
                    if (bus.instr_ready) begin
                        state     <= FETCH;
                        k         <= '0;
                        fetch_pc  <= fetch_pc + ADDR_WIDTH'(4);
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= fetch_pc + ADDR_WIDTH'(4);
                        valid_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.instr_valid = valid_q;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: sync-read byte memory model plus a word-level reference of fetch order.
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         passes = 0;
    logic [7:0] mem [256];
    logic [7:0] cur_pc;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_WIDTH(8)) bus ();

    instr_fetch #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
        .PC  (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory output is only meaningful after a read; otherwise it carries junk.
    always @(posedge clk)
        if (bus.rd_en) bus.mem_dout <= mem[bus.rd_addr];
        else           bus.mem_dout <= 8'($urandom);

    function automatic logic [31:0] ref_instr(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Entered at the sample point of F0 for address a; leaves at the sample point of F5.
    task automatic walk_fetch(input logic [7:0] a, input string tag);
        logic [7:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = a + 8'(i);
            checks++;
            if ({bus.rd_en, bus.rd_addr, bus.instr_valid} !== {1'b1, ea, 1'b0})
                $display("FAIL %s_F%0d: rd_en/rd_addr/valid got %b/%h/%b want 1/%h/0",
                         tag, i, bus.rd_en, bus.rd_addr, bus.instr_valid, ea);
            else passes++;
            step();
        end
        checks++;
        if ({bus.rd_en, bus.instr_valid} !== 2'b00)
            $display("FAIL %s_F4: rd_en/valid got %b/%b want 0/0", tag, bus.rd_en, bus.instr_valid);
        else passes++;
        step();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_addr, bus.rd_en} !== {1'b1, ref_instr(a), a, 1'b0})
            $display("FAIL %s_F5: valid/instr/addr/rd_en got %b/%h/%h/%b want 1/%h/%h/0",
                     tag, bus.instr_valid, bus.instr, bus.instr_addr, bus.rd_en, ref_instr(a), a);
        else passes++;
    endtask

    task automatic test_reset();
        bus.instr_ready   = 1'b1;
        bus.redirect_en   = 1'b0;
        bus.redirect_addr = 8'h00;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.instr, bus.instr_addr, bus.instr_valid, bus.fetch_fault}
            !== {1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_values: rd_en=%b rd_addr=%h instr=%h addr=%h valid=%b fault=%b want all 0",
                     bus.rd_en, bus.rd_addr, bus.instr, bus.instr_addr, bus.instr_valid, bus.fetch_fault);
        else passes++;
        rst = 1'b0;
        step();
        walk_fetch(8'h00, "reset");
        checks++;
        if (bus.instr !== 32'h00500013)
            $display("FAIL reset_instr: got %h want 00500013", bus.instr);
        else passes++;
        step();
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.instr_valid} !== {1'b1, 8'h04, 1'b0})
            $display("FAIL reset_next_f0: rd_en/rd_addr/valid got %b/%h/%b want 1/04/0",
                     bus.rd_en, bus.rd_addr, bus.instr_valid);
        else passes++;
        cur_pc = 8'h04;
    endtask

    task automatic test_backpressure();
        bus.instr_ready = 1'b0;
        walk_fetch(cur_pc, "bp");
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_addr, bus.rd_en} !== {1'b1, ref_instr(cur_pc), cur_pc, 1'b0})
                $display("FAIL bp_hold%0d: valid/instr/addr/rd_en got %b/%h/%h/%b want 1/%h/%h/0",
                         i, bus.instr_valid, bus.instr, bus.instr_addr, bus.rd_en, ref_instr(cur_pc), cur_pc);
            else passes++;
        end
        bus.instr_ready = 1'b1;
        step();
        cur_pc = cur_pc + 8'd4;
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.instr_valid} !== {1'b1, cur_pc, 1'b0})
            $display("FAIL bp_release: rd_en/rd_addr/valid got %b/%h/%b want 1/%h/0",
                     bus.rd_en, bus.rd_addr, bus.instr_valid, cur_pc);
        else passes++;
    endtask

    task automatic test_redirect_mid();
        step();
        step();
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 8'h40;
        step();
        bus.redirect_en = 1'b0;
        walk_fetch(8'h40, "mid");
        step();
        checks++;
        if ({bus.rd_en, bus.rd_addr} !== {1'b1, 8'h44})
            $display("FAIL mid_next_f0: rd_en/rd_addr got %b/%h want 1/44", bus.rd_en, bus.rd_addr);
        else passes++;
        cur_pc = 8'h44;
    endtask

    task automatic test_wrap();
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 8'hFC;
        step();
        bus.redirect_en = 1'b0;
        walk_fetch(8'hFC, "wrap");
        step();
        checks++;
        if ({bus.rd_en, bus.rd_addr} !== {1'b1, 8'h00})
            $display("FAIL wrap_next_f0: rd_en/rd_addr got %b/%h want 1/00", bus.rd_en, bus.rd_addr);
        else passes++;
        cur_pc = 8'h00;
    endtask

    task automatic test_simul();
        bus.instr_ready = 1'b0;
        walk_fetch(cur_pc, "simul_pre");
        bus.instr_ready   = 1'b1;
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 8'h20;
        step();
        bus.redirect_en = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.rd_en, bus.rd_addr} !== {1'b0, 1'b1, 8'h20})
            $display("FAIL simul_after: valid/rd_en/rd_addr got %b/%b/%h want 0/1/20",
                     bus.instr_valid, bus.rd_en, bus.rd_addr);
        else passes++;
        walk_fetch(8'h20, "simul");
        step();
        cur_pc = 8'h24;
    endtask

    task automatic test_misalign();
        bus.redirect_en   = 1'b1;
        bus.redirect_addr = 8'h22;
        step();
        bus.redirect_en = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.fetch_fault, bus.rd_en, bus.instr_valid} !== 3'b100)
                $display("FAIL fault_hold%0d: fault/rd_en/valid got %b/%b/%b want 1/0/0",
                         i, bus.fetch_fault, bus.rd_en, bus.instr_valid);
            else passes++;
            bus.redirect_en   = (i == 3);
            bus.redirect_addr = 8'h30;
            step();
        end
        bus.redirect_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.fetch_fault, bus.rd_en, bus.instr_valid, bus.rd_addr} !== {3'b000, 8'h00})
            $display("FAIL fault_clear: fault/rd_en/valid/rd_addr got %b/%b/%b/%h want 0/0/0/00",
                     bus.fetch_fault, bus.rd_en, bus.instr_valid, bus.rd_addr);
        else passes++;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({bus.rd_en, bus.rd_addr} !== {1'b1, 8'h00})
            $display("FAIL fault_restart: rd_en/rd_addr got %b/%h want 1/00", bus.rd_en, bus.rd_addr);
        else passes++;
        cur_pc = 8'h00;
`else
        checks++;
        if (bus.fetch_fault !== 1'b0)
            $display("FAIL misalign_fault: got %b want 0", bus.fetch_fault);
        else passes++;
        walk_fetch(8'h20, "misalign");
        step();
        cur_pc = 8'h24;
`endif
    endtask

    task automatic test_random();
        int         r;
        int         j;
        int         s;
        logic [7:0] na;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                j  = $urandom_range(0, 5);
                na = {6'($urandom), 2'b00};
                bus.instr_ready = 1'($urandom_range(0, 1));
                for (int c = 0; c < j; c++) step();
                bus.redirect_en   = 1'b1;
                bus.redirect_addr = na;
                step();
                bus.redirect_en = 1'b0;
                bus.instr_ready = 1'b0;
                cur_pc = na;
                checks++;
                if ({bus.rd_en, bus.rd_addr, bus.instr_valid} !== {1'b1, cur_pc, 1'b0})
                    $display("FAIL rand_redirect%0d: rd_en/rd_addr/valid got %b/%h/%b want 1/%h/0",
                             it, bus.rd_en, bus.rd_addr, bus.instr_valid, cur_pc);
                else passes++;
            end else begin
                bus.instr_ready = 1'b0;
                walk_fetch(cur_pc, "rand");
                s = $urandom_range(0, 3);
                for (int c = 0; c < s; c++) begin
                    step();
                    checks++;
                    if ({bus.instr_valid, bus.instr} !== {1'b1, ref_instr(cur_pc)})
                        $display("FAIL rand_stall%0d: valid/instr got %b/%h want 1/%h",
                                 it, bus.instr_valid, bus.instr, ref_instr(cur_pc));
                    else passes++;
                end
                bus.instr_ready = 1'b1;
                step();
                bus.instr_ready = 1'b0;
                cur_pc = cur_pc + 8'd4;
                checks++;
                if ({bus.rd_en, bus.rd_addr, bus.instr_valid} !== {1'b1, cur_pc, 1'b0})
                    $display("FAIL rand_advance%0d: rd_en/rd_addr/valid got %b/%h/%b want 1/%h/0",
                             it, bus.rd_en, bus.rd_addr, bus.instr_valid, cur_pc);
                else passes++;
            end
        end
    endtask

    task automatic test_async_reset();
        bus.instr_ready = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.instr, bus.instr_addr, bus.instr_valid}
            !== {1'b0, 8'h00, 32'h0, 8'h00, 1'b0})
            $display("FAIL async_reset: rd_en=%b rd_addr=%h instr=%h addr=%h valid=%b want all 0",
                     bus.rd_en, bus.rd_addr, bus.instr, bus.instr_addr, bus.instr_valid);
        else passes++;
        step();
        rst = 1'b0;
        step();
        walk_fetch(8'h00, "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13;
        mem[1] = 8'h00;
        mem[2] = 8'h50;
        mem[3] = 8'h00;
        cur_pc = 8'h00;
        test_reset();
        test_backpressure();
        test_redirect_mid();
        test_wrap();
        test_simul();
        test_misalign();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Byte-serial instruction fetch sequencer sitting directly upstream of `instr_mem`. It owns the program counter, issues four consecutive byte reads into the 8-bit-wide, synchronous-read instruction memory, assembles them into a 32-bit little-endian instruction, and presents it to decode over a valid/ready handshake. Control flow changes arrive as a single-cycle redirect.

## Interface
- `ADDR_WIDTH`, default 8: byte address width; must match `instr_mem` `ADDR_WIDTH`.
- `RESET_VECTOR`, default 0: first fetch address; bits [1:0] are ignored and treated as 0.

Ports:
- `PC`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rd_en`, out, 1: read enable to `instr_mem`.
- `rd_addr`, out, ADDR_WIDTH: byte read address to `instr_mem`.
- `mem_dout`, in, 8: read data from `instr_mem`, valid one cycle after `rd_en`/`rd_addr` are sampled.
- `instr`, out, 32: assembled instruction.
- `instr_addr`, out, ADDR_WIDTH: byte address of `instr`.
- `instr_valid`, out, 1: `instr`/`instr_addr` are valid.
- `instr_ready`, in, 1: decode accepts when high with `instr_valid` at a rising edge.
- `redirect_en`, in, 1: one-cycle request to restart fetch at `redirect_addr`.
- `redirect_addr`, in, ADDR_WIDTH: new fetch address.
- `fetch_fault`, out, 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- States: IDLE, FETCH (sub-counter k = 0..4), VALID, FAULT.
- Reset values: state IDLE, fetch pc = RESET_VECTOR with [1:0] = 0, k = 0, `rd_en` 0, `rd_addr` = pc, `instr` 0, `instr_addr` = pc, `instr_valid` 0, `fetch_fault` 0.
- IDLE always moves to FETCH, k = 0, at the next edge.
- FETCH, k = 0..3:
  - `rd_en` = 1 and `rd_addr` = pc + k.
  - Address arithmetic is modulo 2^ADDR_WIDTH, so addresses wrap past the top of memory.
- FETCH, k = 1..4:
  - At the end of cycle k, `mem_dout` is captured into `instr[8(k-1)+7 : 8(k-1)]`.
  - Byte at pc goes to bits [7:0] (little-endian).
- FETCH k = 4: `rd_en` = 0. At the end of the cycle the block enters VALID and `instr_addr` takes pc.
- VALID:
  - `instr_valid` = 1 and `rd_en` = 0.
  - `instr` and `instr_addr` are held stable until the handshake.
  - On `instr_ready`: pc advances by 4 (wrapping), state goes to FETCH with k = 0, and `instr_valid` drops.
- Redirect (`redirect_en` = 1 at an edge, in IDLE, FETCH or VALID):
  - Aborts the fetch in flight.
  - pc takes `redirect_addr`; `instr_valid` goes to 0; state goes to FETCH with k = 0.
  - Partially captured bytes are discarded.
  - Redirect has priority over the handshake. If both happen at the same edge, the current instruction counts as consumed and the next fetch starts at `redirect_addr`.
- `rst` asserted in any state returns all registers to their reset values immediately.

## Timing
- Let F0 be the first FETCH cycle after reset release or a redirect. The edge ending the last reset cycle moves IDLE to FETCH.
- Read requests: `rd_en` is high during F0 through F3.
- Byte capture: at the ends of F1 through F4.
- Instruction out: `instr_valid` is first high in cycle F5.
- Latency from entering FETCH to valid: 5 cycles.
- Throughput with `instr_ready` held high: one instruction per 6 cycles (F0–F4 plus one VALID cycle).
- A redirect at the end of cycle n makes cycle n+1 an F0 cycle with `rd_addr` = `redirect_addr`.
- `instr_valid` never rises without four fresh bytes captured since the last F0.

## Configuration
- Macro `INSTR_FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_addr[1:0]` != 0 enters FAULT instead of FETCH.
  - In FAULT: `fetch_fault` = 1, `rd_en` = 0, `instr_valid` = 0.
  - Further redirects are ignored. Only `rst` leaves FAULT.
- Undefined:
  - `redirect_addr[1:0]` is forced to 0 and fetch proceeds normally.
  - FAULT is unreachable and `fetch_fault` is tied to 0.

## Test plan
- Reset sequencing: memory bytes 0..3 = 13,00,50,00 (hex), `rst` pulse, `instr_ready` = 1. Required: `rd_addr` 0,1,2,3 in F0–F3; `instr` = 32'h00500013 and `instr_addr` = 0 in F5; next F0 has `rd_addr` = 4.
- Backpressure: `instr_ready` = 0 for 10 cycles after `instr_valid`. Required: `instr`, `instr_addr` and `instr_valid` stay stable and `rd_en` stays 0 throughout; pc advances to 4 only after `instr_ready` rises.
- Mid-fetch redirect: redirect to 8'h40 in F2. Required: the next cycle is F0 with `rd_addr` = 8'h40; the delivered `instr` comes from bytes 40..43 (hex) only; `instr_addr` = 8'h40.
- Wrap-around: redirect to 8'hFC, then hold `instr_ready` = 1. Required: reads FC, FD, FE, FF; after the handshake the next F0 has `rd_addr` = 8'h00.
- Simultaneous handshake and redirect to 8'h20. Required: `instr_valid` low in the next cycle, then a fetch from 8'h20; the current instruction is not re-presented.
- Misaligned redirect to 8'h22:
  - With the macro: `fetch_fault` = 1 and `rd_en` = 0 permanently, until `rst` clears both.
  - Without the macro: fetch proceeds from 8'h20.
